wave_dac_driver: RTL and testbench
==================================

Name: wave_dac_driver

Overview:
Downstream output stage for the waveform generator. It accepts signed waveform samples over a valid/ready handshake and applies a programmable gain with saturation. It converts each sample to offset binary for the R-2R DAC and buffers samples in a small FIFO. It presents one sample per programmable DAC update period with an update strobe, and flags underflow when the FIFO runs dry.

Parameters:
DataWidth, 16, sample and DAC word width
FifoDepth, 8, FIFO entries (power of two, >= 2)
DivWidth, 16, width of the DAC update-period divider

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
sample_in  input  DataWidth  signed two's-complement sample
sample_valid  input  1  sample_in valid
sample_ready  output  1  FIFO can accept a sample (= !full)
gain  input  8  unsigned Q1.7 gain; 128 = 1.0
div  input  DivWidth  DAC update period = div+1 clk cycles
enable  input  1  run DAC output
dac_out  output  DataWidth  unsigned offset-binary DAC code (registered)
dac_strobe  output  1  one-cycle pulse when dac_out updates
underflow  output  1  one-cycle pulse: tick with FIFO empty
fifo_level  output  $clog2(FifoDepth+1)  current FIFO occupancy

Behaviour:
- Reset (async, immediate, also mid-operation) sets the following. dac_out = 2^(DataWidth-1), i.e. midscale (0x8000). dac_strobe = 0, underflow = 0. FIFO empty, fifo_level = 0, sample_ready = 1. State = IDLE, divider counter = 0.
- Push: a sample is written when sample_valid && sample_ready. sample_ready derives from registered full only, so a pop and push in the same cycle while full does not accept the push.
- Scaling at write: p = sample_in * {0,gain}, signed, full width. s = p >>> 7 (arithmetic). Saturate s to [-2^(DataWidth-1), 2^(DataWidth-1)-1]. The stored code is s with its MSB inverted (offset binary).
- FSM states:
  - IDLE: divider held at 0, no pops, dac_out holds. Go to FILL when enable=1.
  - FILL: no pops. Go to RUN when fifo_level >= FifoDepth/2.
  - RUN: divider counts 0..div. A tick occurs when counter == div; the counter then reloads 0. div is sampled live; div=0 gives a tick every cycle.
  - From any state, enable=0 returns to IDLE on the next edge. FIFO contents and dac_out are retained.
- On a tick in RUN:
  - FIFO non-empty: pop. dac_out <= head on the same edge; dac_strobe = 1 for that one cycle.
  - FIFO empty: dac_out holds, dac_strobe = 1, underflow = 1 for one cycle. A push in the same cycle does not satisfy that tick. State stays RUN.
- Latency: dac_out is registered and updates one edge after the tick condition. The first sample appears at the first tick after entering RUN.
- Pointers wrap modulo FifoDepth. fifo_level is exact, 0..FifoDepth.

Optional Feature:
DAC_UNDERFLOW_CNT_EN
- Defined: adds output port underflow_cnt [15:0]. It is a saturating count (stops at 0xFFFF) of underflow pulses, cleared by rst and on each IDLE->FILL transition.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset: assert rst mid-RUN with FIFO half full -> immediately dac_out=16'h8000, fifo_level=0, sample_ready=1, dac_strobe=0, underflow=0.
2. Ordering and period: gain=128, div=3, enable=1; push -32768, 0, 32767, 1000 -> RUN after 4th push. Strobes exactly 4 clk apart with dac_out 0x0000, 0x8000, 0xFFFF, 0x83E8.
3. Saturation: gain=255; push 20000 -> code 0xFFFF (39843 clipped); push -20000 -> code 0x0000; gain=64, push 1000 -> 0x81F4.
4. Full boundary: enable=0; push 8 samples -> fifo_level=8, sample_ready=0. A 9th sample held valid is not accepted until enable=1 and the first pop.
5. Underflow: RUN, div=0, drain the FIFO -> on the next tick underflow=1 and dac_strobe=1, dac_out holds the last code. With the macro defined, underflow_cnt increments by 1 per empty tick.
6. Enable drop: deassert enable in RUN with fifo_level=5 -> no further strobes, level stays 5. Reassert -> FILL, immediate RUN (5 >= 4), strobes resume after div+1 cycles.

Source files
------------

// File: rtl/wave_dac_driver.sv
// Gain/saturate signed samples into an offset-binary FIFO and pace them out to an R-2R DAC.
// Optional DAC_UNDERFLOW_CNT_EN adds a saturating underflow_cnt output.
module wave_dac_driver #(
  parameter int DataWidth = 16,
  parameter int FifoDepth = 8,
  parameter int DivWidth  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DataWidth-1:0]             sample_in,
  input  logic                             sample_valid,
  output logic                             sample_ready,
  input  logic [7:0]                       gain,
  input  logic [DivWidth-1:0]              div,
  input  logic                             enable,
  output logic [DataWidth-1:0]             dac_out,
  output logic                             dac_strobe,
  output logic                             underflow,
  output logic [$clog2(FifoDepth+1)-1:0]   fifo_level
`ifdef DAC_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]                      underflow_cnt
`endif
);

  localparam int AddrWidth  = $clog2(FifoDepth);
  localparam int LevelWidth = $clog2(FifoDepth + 1);
  localparam int ProdWidth  = DataWidth + 9;
  localparam logic [LevelWidth-1:0] FullLevel = LevelWidth'(FifoDepth);
  localparam logic [LevelWidth-1:0] HalfLevel = LevelWidth'(FifoDepth / 2);
  localparam logic signed [ProdWidth-1:0] SatMax =
    {{(ProdWidth-DataWidth+1){1'b0}}, {(DataWidth-1){1'b1}}};
  localparam logic signed [ProdWidth-1:0] SatMin =
    {{(ProdWidth-DataWidth+1){1'b1}}, {(DataWidth-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t state, state_next;

  logic [DataWidth-1:0]        mem [FifoDepth];
  logic [AddrWidth-1:0]        wr_ptr, rd_ptr;
  logic [DivWidth-1:0]         div_cnt;
  logic                        full, empty, push, pop, tick;
  logic signed [ProdWidth-1:0] sample_ext, gain_ext, prod, shifted, clipped;
  logic [DataWidth-1:0]        code;

  assign full         = (fifo_level == FullLevel);
  assign empty        = (fifo_level == '0);
  assign sample_ready = !full;
  assign push         = sample_valid && sample_ready;

  // Gain is zero-extended so the product stays signed; offset binary = MSB flipped.
  always_comb begin
    sample_ext = ProdWidth'($signed(sample_in));
    gain_ext   = ProdWidth'({1'b0, gain});
    prod       = sample_ext * gain_ext;
    shifted    = prod >>> 7;
    if (shifted > SatMax)      clipped = SatMax;
    else if (shifted < SatMin) clipped = SatMin;
    else                       clipped = shifted;
    code = {~clipped[DataWidth-1], clipped[DataWidth-2:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = FILL;
        FILL:    if (fifo_level >= HalfLevel) state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    tick = (state == RUN) && (div_cnt == div);
    pop  = tick && !empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                div_cnt <= '0;
    else if (state != RUN)  div_cnt <= '0;
    else if (tick)          div_cnt <= '0;
    else                    div_cnt <= div_cnt + DivWidth'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AddrWidth'(1);
      if (pop)  rd_ptr <= rd_ptr + AddrWidth'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LevelWidth'(1);
        2'b01:   fifo_level <= fifo_level - LevelWidth'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_out    <= {1'b1, {(DataWidth-1){1'b0}}};
      dac_strobe <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      dac_strobe <= tick;
      underflow  <= tick && empty;
      if (pop) dac_out <= mem[rd_ptr];
    end
  end

`ifdef DAC_UNDERFLOW_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      underflow_cnt <= '0;
    else if (state == IDLE && state_next == FILL)
      underflow_cnt <= '0;
    else if (tick && empty && underflow_cnt != '1)
      underflow_cnt <= underflow_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_wave_dac_driver.sv
// Bench for wave_dac_driver: queue-based reference model checked every cycle, plus directed
// literal checks and a randomized phase. Define DAC_UNDERFLOW_CNT_EN to also check underflow_cnt.
module tb_wave_dac_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [7:0]  gain = 8'd128;
  logic [15:0] div = 16'd3;
  logic        enable = 1'b0;
  logic [15:0] dac_out;
  logic        dac_strobe;
  logic        underflow;
  logic [3:0]  fifo_level;
`ifdef DAC_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  always #5 clk = ~clk;

  wave_dac_driver #(.DataWidth(16), .FifoDepth(8), .DivWidth(16)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .gain(gain), .div(div), .enable(enable),
    .dac_out(dac_out), .dac_strobe(dac_strobe), .underflow(underflow),
    .fifo_level(fifo_level)
`ifdef DAC_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0=idle 1=fill 2=run, queue holds stored codes.
  logic [15:0] mq[$];
  int          m_mode;
  int          m_cnt;
  logic [15:0] m_dac;
  logic        m_strobe;
  logic        m_under;
  int          m_ucnt;

  logic [15:0] seen_codes[$];
  time         seen_t[$];
  int          n_under = 0;
  time         edge_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] scale(input logic [15:0] s, input logic [7:0] g);
    longint p;
    p = longint'($signed(s)) * longint'(g);
    p = p >>> 7;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return 16'(p + 32768);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mode = 0; m_cnt = 0; m_dac = 16'h8000;
    m_strobe = 1'b0; m_under = 1'b0; m_ucnt = 0;
  endtask

  task automatic model_step();
    int lvl;
    bit t;
    if (rst) begin
      model_reset();
      return;
    end
    lvl = mq.size();
    t = (m_mode == 2) && (m_cnt == int'(div));
    m_strobe = t;
    m_under  = t && (lvl == 0);
    if (m_under && m_ucnt < 65535) m_ucnt++;
    if (m_mode == 0 && enable) m_ucnt = 0;
    if (t && lvl > 0) m_dac = mq.pop_front();
    if (sample_valid && lvl < 8) mq.push_back(scale(sample_in, gain));
    m_cnt = (m_mode == 2) ? (t ? 0 : (m_cnt + 1) % 65536) : 0;
    if (!enable)                    m_mode = 0;
    else if (m_mode == 0)           m_mode = 1;
    else if (m_mode == 1 && lvl >= 4) m_mode = 2;
  endtask

  always @(posedge clk) begin
    edge_t = $time;
    model_step();
    #1;
    chk("dac_out", 32'(dac_out), 32'(m_dac));
    chk("dac_strobe", 32'(dac_strobe), 32'(m_strobe));
    chk("underflow", 32'(underflow), 32'(m_under));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("sample_ready", 32'(sample_ready), 32'(mq.size() < 8));
`ifdef DAC_UNDERFLOW_CNT_EN
    chk("underflow_cnt", 32'(underflow_cnt), 32'(m_ucnt));
`endif
    if (dac_strobe) begin
      seen_codes.push_back(dac_out);
      seen_t.push_back(edge_t);
    end
    if (underflow) n_under++;
  end

  task automatic push_one(input logic [15:0] v, input logic [7:0] g);
    @(negedge clk);
    sample_in = v; gain = g; sample_valid = 1'b1;
  endtask

  task automatic idle_valid();
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (seen_codes.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("strobe_timeout", 32'(seen_codes.size() >= n), 32'd1);
  endtask

  task automatic clear_seen();
    seen_codes.delete();
    seen_t.delete();
  endtask

  initial begin
    int k;
    int n0;
    int r;
    time t0;
    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dac_out", 32'(dac_out), 32'h8000);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ready", 32'(sample_ready), 32'd1);
    chk("rst_strobe", 32'(dac_strobe), 32'd0);

    // Ordering and period
    clear_seen();
    enable = 1'b1;
    push_one(16'h8000, 8'd128);
    push_one(16'h0000, 8'd128);
    push_one(16'h7FFF, 8'd128);
    push_one(16'd1000, 8'd128);
    idle_valid();
    wait_strobes(4, 60);
    if (seen_codes.size() >= 4) begin
      chk("order_0", 32'(seen_codes[0]), 32'h0000);
      chk("order_1", 32'(seen_codes[1]), 32'h8000);
      chk("order_2", 32'(seen_codes[2]), 32'hFFFF);
      chk("order_3", 32'(seen_codes[3]), 32'h83E8);
      for (int i = 0; i < 3; i++) chk("period", 32'(seen_t[i+1] - seen_t[i]), 32'd40);
    end
    repeat (6) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    // Saturation
    clear_seen();
    push_one(16'd20000, 8'd255);
    push_one(16'hB1E0, 8'd255);
    push_one(16'd1000, 8'd64);
    push_one(16'd0, 8'd64);
    idle_valid();
    enable = 1'b1;
    wait_strobes(3, 60);
    if (seen_codes.size() >= 3) begin
      chk("sat_pos", 32'(seen_codes[0]), 32'hFFFF);
      chk("sat_neg", 32'(seen_codes[1]), 32'h0000);
      chk("gain_half", 32'(seen_codes[2]), 32'h81F4);
    end
    repeat (10) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // Full boundary, then drain to underflow with div=0
    for (int i = 0; i < 8; i++) push_one(16'($urandom), 8'($urandom));
    @(negedge clk);
    sample_in = 16'($urandom);
    repeat (5) @(negedge clk);
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_ready", 32'(sample_ready), 32'd0);
    div = 16'd0;
    enable = 1'b1;
    k = 0;
    while (!sample_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_timeout", 32'(sample_ready), 32'd1);
    @(negedge clk);
    sample_valid = 1'b0;
    n0 = n_under;
    k = 0;
    while (n_under == n0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("underflow_seen", 32'(n_under > n0), 32'd1);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // Enable drop at level 5, resume, then mid-run async reset
    div = 16'd2;
    for (int i = 0; i < 8; i++) push_one(16'($urandom), 8'd128);
    idle_valid();
    clear_seen();
    enable = 1'b1;
    wait_strobes(3, 60);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("drop_level", 32'(fifo_level), 32'd5);
    chk("drop_no_strobe", 32'(seen_codes.size()), 32'd3);
    clear_seen();
    t0 = $time;
    enable = 1'b1;
    wait_strobes(1, 20);
    if (seen_t.size() >= 1) chk("resume_delay", 32'(seen_t[0] - t0), 32'd45);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_dac_out", 32'(dac_out), 32'h8000);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_ready", 32'(sample_ready), 32'd1);
    chk("arst_strobe", 32'(dac_strobe), 32'd0);
    chk("arst_underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      sample_valid = 1'($urandom);
      sample_in = 16'($urandom);
      if (r < 6) gain = 8'($urandom);
      if (!enable && r < 20) div = 16'($urandom_range(0, 4));
      if (r >= 96 && r < 99) enable = !enable;
      if (r == 99) begin
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
